// File: rtl/periodic_stream_monitor.sv
// Output-only runtime monitor: two periodic streams paced by cycle timers, events queued then evaluated.
// Optional macro ZERO_WHEN_INACTIVE_EN: stream outputs read 0 in cycles where their aktv flag is low.
module periodic_stream_monitor #(
    parameter int PERIOD0     = 500,
    parameter int PERIOD1     = 1000,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic signed [63:0] output_0,
    output logic               output_0_aktv,
    output logic signed [63:0] output_1,
    output logic               output_1_aktv,
    output logic               q_push,
    output logic               q_pop,
    output logic               q_push_valid,
    output logic               q_pop_valid,
    output logic               pacing_0,
    output logic               pacing_1
);

    localparam int C0W = (PERIOD0 > 1) ? $clog2(PERIOD0) : 1;
    localparam int C1W = (PERIOD1 > 1) ? $clog2(PERIOD1) : 1;
    localparam int AW  = $clog2(QUEUE_DEPTH);

    logic [C0W-1:0] c0;
    logic [C1W-1:0] c1;
    logic           dl0, dl1;

    assign dl0 = en && (c0 == C0W'(PERIOD0 - 1));
    assign dl1 = en && (c1 == C1W'(PERIOD1 - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0 <= '0;
            c1 <= '0;
        end else if (en) begin
            c0 <= dl0 ? '0 : c0 + C0W'(1);
            c1 <= dl1 ? '0 : c1 + C1W'(1);
        end
    end

    // Event queue: pointers carry one extra wrap bit to tell full from empty.
    logic [1:0]  mem [QUEUE_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign q_push       = dl0 | dl1;
    assign q_pop        = en & ~empty;
    // A same-cycle pop frees the slot the push needs, so a full queue still accepts.
    assign q_push_valid = q_push & (~full | q_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (q_push_valid) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (q_pop)        rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: queue storage has no reset; entries are only read after the pointers say they were written.
    always_ff @(posedge clk) begin
        if (q_push_valid) mem[wr_ptr[AW-1:0]] <= {dl1, dl0};
    end

    // Evaluator register: holds the freshly popped event for one cycle.
    logic       pv_r;
    logic [1:0] pac_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_r  <= 1'b0;
            pac_r <= 2'b00;
        end else if (en) begin
            pv_r  <= q_pop;
            pac_r <= q_pop ? mem[rd_ptr[AW-1:0]] : 2'b00;
        end
    end

    assign q_pop_valid = pv_r & en;
    assign pacing_0    = pac_r[0] & en;
    assign pacing_1    = pac_r[1] & en;

    // Stream evaluation.
    logic signed [63:0] val0, val1;
    logic signed [63:0] next0, next1;
    logic               a0_r, a1_r;
    logic               ev0, ev1;

    assign ev0 = pv_r & pac_r[0];
    assign ev1 = pv_r & pac_r[1];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next0 = val0;
        next1 = val1;
        if (ev0) next0 = val0 + 64'sd1;
        // Stream 1 sums against the output_0 value produced by this same event.
        if (ev1) next1 = val1 + next0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val0 <= '0;
            val1 <= '0;
            a0_r <= 1'b0;
            a1_r <= 1'b0;
        end else if (en) begin
            val0 <= next0;
            val1 <= next1;
            a0_r <= ev0;
            a1_r <= ev1;
        end else begin
            a0_r <= 1'b0;
            a1_r <= 1'b0;
        end
    end

    assign output_0_aktv = a0_r & en;
    assign output_1_aktv = a1_r & en;

`ifdef ZERO_WHEN_INACTIVE_EN
    assign output_0 = output_0_aktv ? val0 : 64'sd0;
    assign output_1 = output_1_aktv ? val1 : 64'sd0;
`else
    assign output_0 = val0;
    assign output_1 = val1;
`endif

endmodule

// File: tb/tb_periodic_stream_monitor.sv
// Self-checking bench for periodic_stream_monitor: pipeline vector table, long-run stream model,
// enable freeze, forced queue fill, and async reset in flight.
module tb_periodic_stream_monitor;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic signed [63:0] output_0, output_1;
    logic               output_0_aktv, output_1_aktv;
    logic               q_push, q_pop, q_push_valid, q_pop_valid, pacing_0, pacing_1;

    periodic_stream_monitor dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .output_0      (output_0),
        .output_0_aktv (output_0_aktv),
        .output_1      (output_1),
        .output_1_aktv (output_1_aktv),
        .q_push        (q_push),
        .q_pop         (q_pop),
        .q_push_valid  (q_push_valid),
        .q_pop_valid   (q_pop_valid),
        .pacing_0      (pacing_0),
        .pacing_1      (pacing_1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Samples and drives happen on the falling edge, half a cycle away from the active edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [63:0] shown(input longint v, input logic a);
`ifdef ZERO_WHEN_INACTIVE_EN
        return a ? 64'(v) : 64'd0;
`else
        return (a | ~a) ? 64'(v) : 64'd0;
`endif
    endfunction

    typedef struct {
        int   cyc;
        logic pop;
        logic pv;
        logic p0;
        logic p1;
        logic pushv;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        longint m0, m1;
        logic   ep, ea0, ea1, epop, epv;
        int     vi, n_a0, n_a1;

        vec[0] = '{0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[1] = '{499,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[2] = '{500,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[3] = '{501,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[4] = '{502,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[5] = '{999,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vec[6] = '{1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[7] = '{1001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vec[8] = '{1002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[9] = '{1501, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset state
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_output_0", output_0, 64'd0);
        check("rst_output_1", output_1, 64'd0);
        check("rst_aktv0", 64'(output_0_aktv), 64'd0);
        check("rst_q_pop_valid", 64'(q_pop_valid), 64'd0);

        // Long run from reset release with pipeline vector table
        rst = 1'b0;
        en  = 1'b1;
        cyc = 0;
        m0  = 0;
        m1  = 0;
        vi  = 0;
        while (cyc <= 4005) begin
            ep  = (cyc >= 499)  && ((cyc - 499)  % 500 == 0);
            ea0 = (cyc >= 502)  && ((cyc - 502)  % 500 == 0);
            ea1 = (cyc >= 1002) && ((cyc - 1002) % 1000 == 0);
            if (ea0) m0 = m0 + 1;
            if (ea1) m1 = m1 + m0;
            check("run_q_push", 64'(q_push), 64'(ep));
            check("run_aktv0", 64'(output_0_aktv), 64'(ea0));
            check("run_aktv1", 64'(output_1_aktv), 64'(ea1));
            check("run_output_0", output_0, shown(m0, ea0));
            check("run_output_1", output_1, shown(m1, ea1));
            if (pacing_1) check("pacing_1_without_0", 64'(pacing_0), 64'd1);
            if (vi < NV && vec[vi].cyc == cyc) begin
                check("vec_q_pop", 64'(q_pop), 64'(vec[vi].pop));
                check("vec_q_pop_valid", 64'(q_pop_valid), 64'(vec[vi].pv));
                check("vec_pacing_0", 64'(pacing_0), 64'(vec[vi].p0));
                check("vec_pacing_1", 64'(pacing_1), 64'(vec[vi].p1));
                check("vec_q_push_valid", 64'(q_push_valid), 64'(vec[vi].pushv));
                vi++;
            end
            tick();
        end
        check("vectors_applied", 64'(vi), 64'(NV));
        check("long_run_final_o0", 64'(m0), 64'd8);
        check("long_run_final_o1", 64'(m1), 64'd20);

        // Enable low for 300 cycles mid-period: deadline 4499 moves to 4799
        while (cyc <= 4803) begin
            ep   = (cyc == 4799);
            epop = (cyc == 4800);
            epv  = (cyc == 4801);
            ea0  = (cyc == 4802);
            if (ea0) m0 = m0 + 1;
            check("en_q_push", 64'(q_push), 64'(ep));
            check("en_q_pop", 64'(q_pop), 64'(epop));
            check("en_q_pop_valid", 64'(q_pop_valid), 64'(epv));
            check("en_aktv0", 64'(output_0_aktv), 64'(ea0));
            check("en_aktv1", 64'(output_1_aktv), 64'd0);
            check("en_output_0", output_0, shown(m0, ea0));
            check("en_output_1", output_1, shown(m1, 1'b0));
            if (cyc == 4100) en = 1'b0;
            if (cyc == 4400) en = 1'b1;
            tick();
        end
        check("en_final_o0", 64'(m0), 64'd9);

        // Hold the pop side off until the queue fills, then release and drain
        rst = 1'b1;
        force dut.q_pop = 1'b0;
        repeat (2) @(negedge clk);
        rst  = 1'b0;
        cyc  = 0;
        n_a0 = 0;
        n_a1 = 0;
        while (cyc <= 2700) begin
            ep = (cyc == 499) || (cyc == 999) || (cyc == 1499) || (cyc == 1999) || (cyc == 2499);
            check("fill_q_push", 64'(q_push), 64'(ep));
            check("fill_q_push_valid", 64'(q_push_valid), 64'(ep && cyc != 2499));
            if (output_0_aktv) n_a0++;
            if (output_1_aktv) n_a1++;
            if (cyc == 2610) check("drain_q_pop_done", 64'(q_pop), 64'd0);
            if (cyc == 2600) release dut.q_pop;
            tick();
        end
        check("drain_count_aktv0", 64'(n_a0), 64'd4);
        check("drain_count_aktv1", 64'(n_a1), 64'd2);
        check("drain_output_0", output_0, shown(4, 1'b0));
        check("drain_output_1", output_1, shown(6, 1'b0));

        // Async reset between q_pop and q_pop_valid
        while (cyc < 3000) tick();
        check("inflight_q_pop", 64'(q_pop), 64'd1);
        rst = 1'b1;
        #1;
        check("async_output_0", output_0, 64'd0);
        check("async_output_1", output_1, 64'd0);
        check("async_q_pop", 64'(q_pop), 64'd0);
        check("async_q_pop_valid", 64'(q_pop_valid), 64'd0);
        @(negedge clk);
        repeat (3) begin
            tick();
            check("async_hold_aktv0", 64'(output_0_aktv), 64'd0);
            check("async_hold_q_pop_valid", 64'(q_pop_valid), 64'd0);
        end
        rst = 1'b0;
        cyc = 0;
        while (cyc <= 502) begin
            check("restart_q_push", 64'(q_push), 64'(cyc == 499));
            check("restart_aktv0", 64'(output_0_aktv), 64'(cyc == 502));
            tick();
        end
        check("restart_output_0", output_0, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
